// File: rtl/proc_defs_pkg.sv
// Shared definitions for the fetch stage: datapath width, reset PC,
// next-PC source encodings and fetch FSM state codes.
package proc_defs;

    localparam int              WIDTH    = 16;
    localparam logic [WIDTH-1:0] RESET_PC = 16'h0000;

    typedef enum logic [1:0] {
        PCSRC_INC  = 2'b00,
        PCSRC_BR   = 2'b01,
        PCSRC_JMP  = 2'b10,
        PCSRC_HOLD = 2'b11
    } pcsrc_e;

    typedef enum logic [1:0] {
        ST_REQ  = 2'b00,
        ST_WAIT = 2'b01,
        ST_HOLD = 2'b10
    } state_e;

endpackage

// File: rtl/pc_next_calc.sv
// Combinational next-PC selection: PC+1, PC+Imm when a branch is taken,
// an absolute jump target, or the current PC for a refetch.
module pc_next_calc #(
    parameter int WIDTH = proc_defs::WIDTH
) (
    input  logic [WIDTH-1:0] pc,
    input  logic [1:0]       pc_src,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] imm,
    input  logic [WIDTH-1:0] jump_target,
    output logic [WIDTH-1:0] next_pc
);
    import proc_defs::*;

    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] pc_branch;

    // Both sums wrap modulo 2^WIDTH; no overflow is reported.
    assign pc_inc    = pc + 1'b1;
    assign pc_branch = pc + imm;

    always_comb begin
        // NOTE: default first so every path assigns next_pc and no latch is inferred.
        next_pc = pc_inc;
        case (pcsrc_e'(pc_src))
            PCSRC_INC:  next_pc = pc_inc;
            PCSRC_BR:   next_pc = branch_taken ? pc_branch : pc_inc;
            PCSRC_JMP:  next_pc = jump_target;
            PCSRC_HOLD: next_pc = pc;
            default:    next_pc = pc_inc;
        endcase
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch stage: owns the PC, issues instruction-memory reads, latches the
// returned word into IR and advances the PC when control commits PCWrite.
module pc_fetch_unit #(
    parameter int               WIDTH    = proc_defs::WIDTH,
    parameter logic [WIDTH-1:0] RESET_PC = proc_defs::RESET_PC
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             PCWrite,
    input  logic [1:0]       PCSrc,
    input  logic             BranchTaken,
    input  logic [WIDTH-1:0] Imm,
    input  logic [WIDTH-1:0] JumpTarget,
    input  logic             imem_ready,
    input  logic             imem_valid,
    input  logic [WIDTH-1:0] imem_rdata,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    output logic [WIDTH-1:0] PC,
    output logic [WIDTH-1:0] OldPC,
    output logic [WIDTH-1:0] IR,
    output logic             ir_valid,
    output logic             busy
);
    import proc_defs::*;

    state_e           state_q;
    state_e           state_d;
    logic             fetch_en;
    logic             pc_commit;
    logic             ir_load;
    logic [WIDTH-1:0] next_pc;

    pc_next_calc #(.WIDTH(WIDTH)) u_next_calc (
        .pc           (PC),
        .pc_src       (PCSrc),
        .branch_taken (BranchTaken),
        .imm          (Imm),
        .jump_target  (JumpTarget),
        .next_pc      (next_pc)
    );

    // fetch_en keeps the request low while reset is held; the first edge
    // after release arms it, so fetching starts from that edge on.
    assign pc_commit = (state_q == ST_HOLD) && PCWrite;
    assign ir_load   = (state_q == ST_WAIT) && imem_valid;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q <= ST_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_REQ:  if (fetch_en && imem_ready) state_d = ST_WAIT;
            ST_WAIT: if (imem_valid)             state_d = ST_HOLD;
            ST_HOLD: if (PCWrite)                state_d = ST_REQ;
            default:                             state_d = ST_REQ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fetch_en <= 1'b0;
            PC       <= RESET_PC;
            OldPC    <= '0;
            IR       <= '0;
            ir_valid <= 1'b0;
        end else begin
            fetch_en <= 1'b1;
            if (ir_load) begin
                IR       <= imem_rdata;
                OldPC    <= PC;
                ir_valid <= 1'b1;
            end
            if (pc_commit) begin
                PC       <= next_pc;
                ir_valid <= 1'b0;
            end
        end
    end

    assign imem_req  = fetch_en && (state_q == ST_REQ);
    assign imem_addr = PC;
    assign busy      = (state_q != ST_HOLD);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Self-checking bench for pc_fetch_unit: directed scenarios plus a randomized
// run checked against a next-PC / fetch model built from the fetch rules.
module tb_pc_fetch_unit;

    logic        CLK;
    logic        RST;
    logic        PCWrite;
    logic [1:0]  PCSrc;
    logic        BranchTaken;
    logic [15:0] Imm;
    logic [15:0] JumpTarget;
    logic        imem_ready;
    logic        imem_valid;
    logic [15:0] imem_rdata;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic [15:0] PC;
    logic [15:0] OldPC;
    logic [15:0] IR;
    logic        ir_valid;
    logic        busy;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_pc;
    logic [15:0] m_ir;
    logic [15:0] m_oldpc;

    pc_fetch_unit #(.WIDTH(16), .RESET_PC(16'h0000)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .PCWrite     (PCWrite),
        .PCSrc       (PCSrc),
        .BranchTaken (BranchTaken),
        .Imm         (Imm),
        .JumpTarget  (JumpTarget),
        .imem_ready  (imem_ready),
        .imem_valid  (imem_valid),
        .imem_rdata  (imem_rdata),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .PC          (PC),
        .OldPC       (OldPC),
        .IR          (IR),
        .ir_valid    (ir_valid),
        .busy        (busy)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Instruction memory contents: word at address a is 16'hA000 + a.
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return 16'hA000 + a;
    endfunction

    // Next PC from the fetch rules, using 32-bit arithmetic reduced modulo 2^16.
    function automatic logic [15:0] ref_next(input logic [15:0] pc, input logic [1:0] src,
                                             input logic taken, input logic [15:0] imm,
                                             input logic [15:0] jt);
        logic [31:0] v;
        case (src)
            2'd0:    v = 32'(pc) + 32'd1;
            2'd1:    v = taken ? 32'(pc) + 32'(imm) : 32'(pc) + 32'd1;
            2'd2:    v = 32'(jt);
            default: v = 32'(pc);
        endcase
        return v[15:0];
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Acts as the instruction memory for one fetch; ready after rd cycles,
    // data rd+1+vd cycles later. Also advances the fetch model.
    task automatic serve_fetch(input int rd, input int vd);
        logic [15:0] a;
        int n;
        n = 0;
        while (!imem_req) begin
            if (n == 16) begin
                $display("FAIL fetch_timeout: imem_req stayed %b, required 1", imem_req);
                $fatal(1, "fetch timeout");
            end
            tick();
            n++;
        end
        repeat (rd) tick();
        a = imem_addr;
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        repeat (vd) tick();
        imem_valid = 1'b1;
        imem_rdata = mem_word(a);
        tick();
        imem_valid = 1'b0;
        imem_rdata = '0;
        m_ir    = mem_word(m_pc);
        m_oldpc = m_pc;
    endtask

    task automatic commit(input logic [1:0] src, input logic taken,
                          input logic [15:0] imm, input logic [15:0] jt);
        PCWrite = 1'b1; PCSrc = src; BranchTaken = taken; Imm = imm; JumpTarget = jt;
        tick();
        PCWrite = 1'b0;
        m_pc = ref_next(m_pc, src, taken, imm, jt);
    endtask

    task automatic test_reset();
        RST = 1'b0;
        #2 RST = 1'b1;
        repeat (3) tick();
        checks++;
        if (PC !== 16'h0000 || IR !== 16'h0000 || OldPC !== 16'h0000 || ir_valid !== 1'b0 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: PC %h IR %h OldPC %h ir_valid %b req %b, required 0 0 0 0 0",
                     PC, IR, OldPC, ir_valid, imem_req);
        end
        RST = 1'b0;
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin
            errors++;
            $display("FAIL reset_release_req: req %b addr %h, required 1 0000", imem_req, imem_addr);
        end
        m_pc = 16'h0000;
        serve_fetch(0, 0);
        commit(2'b00, 1'b0, 16'h0, 16'h0);
        // Reach WAIT for address 1, then reset asynchronously mid-cycle.
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        #2 RST = 1'b1;
        #1;
        checks++;
        if (PC !== 16'h0000 || IR !== 16'h0000 || ir_valid !== 1'b0 || imem_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: PC %h IR %h ir_valid %b req %b, required 0000 0000 0 0",
                     PC, IR, ir_valid, imem_req);
        end
        tick();
        imem_valid = 1'b1;
        imem_rdata = 16'hDEAD;
        tick();
        imem_valid = 1'b0;
        imem_rdata = '0;
        RST = 1'b0;
        tick();
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 16'h0000 || IR !== 16'h0000) begin
            errors++;
            $display("FAIL reset_abandon: req %b addr %h IR %h, required 1 0000 0000",
                     imem_req, imem_addr, IR);
        end
        m_pc = 16'h0000; m_ir = 16'h0000; m_oldpc = 16'h0000;
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 14; i++) begin
            checks++;
            if (imem_addr !== 16'(i)) begin
                errors++;
                $display("FAIL seq_addr[%0d]: got %h required %h", i, imem_addr, 16'(i));
            end
            serve_fetch(0, 0);
            checks++;
            if (IR !== 16'hA000 + 16'(i) || OldPC !== 16'(i) || ir_valid !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL seq_ir[%0d]: IR %h OldPC %h ir_valid %b busy %b, required %h %h 1 0",
                         i, IR, OldPC, ir_valid, busy, 16'hA000 + 16'(i), 16'(i));
            end
            commit(2'b00, 1'b0, 16'h0, 16'h0);
            checks++;
            if (PC !== 16'(i + 1) || imem_req !== 1'b1) begin
                errors++;
                $display("FAIL seq_pc[%0d]: PC %h req %b, required %h 1", i, PC, imem_req, 16'(i + 1));
            end
        end
    endtask

    task automatic test_branch();
        serve_fetch(0, 0);
        commit(2'b10, 1'b0, 16'h0, 16'h0005);
        serve_fetch(0, 0);
        commit(2'b01, 1'b1, 16'hFFFD, 16'h0);
        checks++;
        if (PC !== 16'h0002) begin
            errors++;
            $display("FAIL branch_taken: PC %h required 0002", PC);
        end
        serve_fetch(0, 0);
        commit(2'b10, 1'b0, 16'h0, 16'h0005);
        serve_fetch(0, 0);
        commit(2'b01, 1'b0, 16'hFFFD, 16'h0);
        checks++;
        if (PC !== 16'h0006) begin
            errors++;
            $display("FAIL branch_not_taken: PC %h required 0006", PC);
        end
        serve_fetch(0, 0);
        commit(2'b11, 1'b1, 16'h0040, 16'h1234);
        checks++;
        if (PC !== 16'h0006 || imem_req !== 1'b1 || imem_addr !== 16'h0006) begin
            errors++;
            $display("FAIL pcsrc_hold: PC %h req %b addr %h, required 0006 1 0006", PC, imem_req, imem_addr);
        end
    endtask

    task automatic test_jump_wrap();
        serve_fetch(0, 0);
        commit(2'b10, 1'b0, 16'h0, 16'hFFFF);
        checks++;
        if (PC !== 16'hFFFF || imem_addr !== 16'hFFFF) begin
            errors++;
            $display("FAIL jump_target: PC %h addr %h, required ffff ffff", PC, imem_addr);
        end
        serve_fetch(0, 0);
        checks++;
        if (IR !== 16'h9FFF || OldPC !== 16'hFFFF) begin
            errors++;
            $display("FAIL jump_fetch: IR %h OldPC %h, required 9fff ffff", IR, OldPC);
        end
        commit(2'b00, 1'b0, 16'h0, 16'h0);
        checks++;
        if (PC !== 16'h0000) begin
            errors++;
            $display("FAIL pc_wrap: PC %h required 0000", PC);
        end
    endtask

    task automatic test_stalls();
        logic [15:0] a;
        a = imem_addr;
        for (int i = 0; i < 3; i++) begin
            imem_ready = 1'b0;
            tick();
            checks++;
            if (imem_req !== 1'b1 || IR !== m_ir || ir_valid !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL stall_req[%0d]: req %b IR %h ir_valid %b busy %b, required 1 %h 0 1",
                         i, imem_req, IR, ir_valid, busy, m_ir);
            end
        end
        // Ready and valid together in REQ: only ready is honoured.
        imem_ready = 1'b1; imem_valid = 1'b1; imem_rdata = 16'hBEEF;
        tick();
        imem_ready = 1'b0; imem_valid = 1'b0; imem_rdata = '0;
        checks++;
        if (imem_req !== 1'b0 || busy !== 1'b1 || IR !== m_ir || ir_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_ready_valid: req %b busy %b IR %h ir_valid %b, required 0 1 %h 0",
                     imem_req, busy, IR, ir_valid, m_ir);
        end
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin
                PCWrite = 1'b1; PCSrc = 2'b10; JumpTarget = 16'h1234;
            end
            tick();
            PCWrite = 1'b0;
            checks++;
            if (PC !== m_pc || IR !== m_ir || ir_valid !== 1'b0) begin
                errors++;
                $display("FAIL stall_wait[%0d]: PC %h IR %h ir_valid %b, required %h %h 0",
                         i, PC, IR, ir_valid, m_pc, m_ir);
            end
        end
        imem_valid = 1'b1;
        imem_rdata = mem_word(a);
        tick();
        imem_valid = 1'b0;
        imem_rdata = '0;
        m_ir = mem_word(m_pc);
        m_oldpc = m_pc;
        checks++;
        if (IR !== m_ir || OldPC !== m_oldpc || ir_valid !== 1'b1 || PC !== m_pc) begin
            errors++;
            $display("FAIL stall_done: IR %h OldPC %h ir_valid %b PC %h, required %h %h 1 %h",
                     IR, OldPC, ir_valid, PC, m_ir, m_oldpc, m_pc);
        end
    endtask

    task automatic test_spurious_valid();
        imem_valid = 1'b1;
        imem_rdata = 16'hDEAD;
        repeat (2) tick();
        imem_valid = 1'b0;
        imem_rdata = '0;
        checks++;
        if (IR !== m_ir || ir_valid !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL spurious_valid: IR %h ir_valid %b busy %b, required %h 1 0",
                     IR, ir_valid, busy, m_ir);
        end
        commit(2'b00, 1'b0, 16'h0, 16'h0);
    endtask

    task automatic test_random();
        logic [1:0]  src;
        logic        taken;
        logic [15:0] imm;
        logic [15:0] jt;
        for (int n = 0; n < 40; n++) begin
            checks++;
            if (imem_addr !== m_pc) begin
                errors++;
                $display("FAIL rand_addr[%0d]: got %h required %h", n, imem_addr, m_pc);
            end
            serve_fetch(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            if ($urandom_range(0, 1) == 1) begin
                imem_valid = 1'b1;
                imem_rdata = 16'($urandom);
                tick();
                imem_valid = 1'b0;
                imem_rdata = '0;
            end
            checks++;
            if (IR !== m_ir || OldPC !== m_oldpc || ir_valid !== 1'b1) begin
                errors++;
                $display("FAIL rand_ir[%0d]: IR %h OldPC %h ir_valid %b, required %h %h 1",
                         n, IR, OldPC, ir_valid, m_ir, m_oldpc);
            end
            src   = 2'($urandom_range(0, 3));
            taken = 1'($urandom_range(0, 1));
            imm   = 16'($urandom);
            jt    = 16'($urandom);
            commit(src, taken, imm, jt);
            checks++;
            if (PC !== m_pc) begin
                errors++;
                $display("FAIL rand_pc[%0d]: src %0d taken %b got %h required %h", n, src, taken, PC, m_pc);
            end
        end
    endtask

    initial begin
        RST = 1'b0; PCWrite = 1'b0; PCSrc = 2'b00; BranchTaken = 1'b0;
        Imm = '0; JumpTarget = '0; imem_ready = 1'b0; imem_valid = 1'b0; imem_rdata = '0;
        m_pc = '0; m_ir = '0; m_oldpc = '0;
        test_reset();
        test_sequential();
        test_branch();
        test_jump_wrap();
        test_stalls();
        test_spurious_valid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
